// File: rtl/dmg_pkg.sv
// Shared LCD geometry and capture-state encoding for the DMG display path.
package dmg_pkg;

    localparam int LCD_W = 160;
    localparam int LCD_H = 144;

    typedef enum logic [1:0] {
        WAIT_VSYNC = 2'd0,
        ACTIVE     = 2'd1,
        FLUSH      = 2'd2
    } cap_state_t;

endpackage

// File: rtl/lcd_frame_capture_packer.sv
// Packs 2bpp pixels four to a byte, first pixel in the top bits; a flush emits
// a partial group padded with zero shades.
module lcd_pixel_packer
    import dmg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       pix_valid,
    input  logic [1:0] pix_color,
    input  logic       flush,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    logic [7:0] pack;
    logic [7:0] pack_n;
    logic [1:0] cnt;
    logic [1:0] cnt_n;
    logic [1:0] pad_n;
    logic [3:0] pad_sh;
    logic       full;

    always_comb begin
        pack_n = pix_valid ? {pack[5:0], pix_color} : pack;
        cnt_n  = cnt + {1'b0, pix_valid};
        full   = pix_valid && (cnt == 2'd3);
        // number of empty slots left in the group, scaled to bits
        pad_n  = 2'd0 - cnt_n;
        pad_sh = {1'b0, pad_n, 1'b0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pack       <= 8'd0;
            cnt        <= 2'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'd0;
        end else begin
            byte_valid <= 1'b0;
            pack       <= pack_n;
            cnt        <= cnt_n;
            if (full) begin
                byte_valid <= 1'b1;
                byte_data  <= pack_n;
            end else if (flush && (cnt_n != 2'd0)) begin
                byte_valid <= 1'b1;
                byte_data  <= pack_n << pad_sh;
                cnt        <= 2'd0;
                pack       <= 8'd0;
            end
            if (clear) begin
                cnt  <= 2'd0;
                pack <= 8'd0;
            end
        end
    end

endmodule

// File: rtl/lcd_frame_capture.sv
// Captures the DMG LCD pixel stream into a double-buffered packed framebuffer,
// swapping banks only when a whole frame has landed in the back bank.
//
// state      | meaning
// WAIT_VSYNC | idle between frames, pixels and hsync ignored
// ACTIVE     | accepting pixels of the current line
// FLUSH      | partial byte being written, line end applied on exit
module lcd_frame_capture
    import dmg_pkg::*;
#(
    parameter int H_PIXELS = LCD_W,
    parameter int V_LINES  = LCD_H,
    parameter int ADDR_W   = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lcd_vsync,
    input  logic              lcd_hsync,
    input  logic              lcd_pixel,
    input  logic [1:0]        lcd_color,
    input  logic              err_clr,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_wdata,
    output logic              front_bank,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic              err_long_line,
    output logic              err_short_line,
    output logic              err_short_frame
);

    localparam int             BW         = ADDR_W - 1;
    localparam logic [7:0]     H_END      = 8'(H_PIXELS);
    localparam logic [7:0]     V_END      = 8'(V_LINES);
    localparam logic [BW-1:0]  LINE_BYTES = BW'(H_PIXELS / 4);

    cap_state_t    state;
    logic          vs_q, vs_prev, hs_q, hs_prev;
    logic [7:0]    x, y;
    logic [BW-1:0] line_base;
    logic          back;

    logic          vs_edge, hs_edge, hs_act;
    logic          pix_accept, pix_long, do_flush, line_end, frame_end, wr_now;
    logic [7:0]    x_after, y_inc;
    logic [BW-1:0] wr_addr;

    always_comb begin
        vs_edge    = vs_q & ~vs_prev;
        hs_edge    = hs_q & ~hs_prev;
        pix_accept = (state == ACTIVE) && lcd_pixel && (x < H_END);
        pix_long   = (state == ACTIVE) && lcd_pixel && (x == H_END);
        x_after    = x + {7'd0, pix_accept};
        hs_act     = (state == ACTIVE) && hs_edge;
        do_flush   = hs_act && (x_after[1:0] != 2'd0);
        line_end   = (hs_act && !do_flush) || (state == FLUSH);
        y_inc      = y + 8'd1;
        frame_end  = line_end && (y_inc == V_END);
        wr_now     = (pix_accept && (x[1:0] == 2'd3)) || do_flush;
        wr_addr    = line_base + BW'(x[7:2]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= WAIT_VSYNC;
            vs_q            <= 1'b1;
            vs_prev         <= 1'b1;
            hs_q            <= 1'b1;
            hs_prev         <= 1'b1;
            x               <= 8'd0;
            y               <= 8'd0;
            line_base       <= '0;
            back            <= 1'b0;
            fb_addr         <= '0;
            front_bank      <= 1'b0;
            frame_done      <= 1'b0;
            frame_count     <= 8'd0;
            err_long_line   <= 1'b0;
            err_short_line  <= 1'b0;
            err_short_frame <= 1'b0;
        end else begin
            vs_q       <= lcd_vsync;
            vs_prev    <= vs_q;
            hs_q       <= lcd_hsync;
            hs_prev    <= hs_q;
            frame_done <= 1'b0;

            if (err_clr) begin
                err_long_line   <= 1'b0;
                err_short_line  <= 1'b0;
                err_short_frame <= 1'b0;
            end
            if (pix_long)
                err_long_line <= 1'b1;
            if (hs_act && (x_after != H_END))
                err_short_line <= 1'b1;

            if (wr_now)
                fb_addr <= {back, wr_addr};

            if (state == ACTIVE)
                x <= x_after;
            if (do_flush)
                state <= FLUSH;

            if (line_end) begin
                x         <= 8'd0;
                y         <= y_inc;
                line_base <= line_base + LINE_BYTES;
                state     <= ACTIVE;
                if (frame_end) begin
                    front_bank  <= back;
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 8'd1;
                    state       <= WAIT_VSYNC;
                end
            end

            // a vsync landing on the last line end starts the next frame straight away
            if (vs_edge) begin
                x         <= 8'd0;
                y         <= 8'd0;
                line_base <= '0;
                state     <= ACTIVE;
                if (state == WAIT_VSYNC)
                    back <= ~front_bank;
                else if (frame_end)
                    back <= ~back;
                else
                    err_short_frame <= 1'b1;
            end
        end
    end

    lcd_pixel_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (vs_edge),
        .pix_valid  (pix_accept),
        .pix_color  (lcd_color),
        .flush      (do_flush),
        .byte_valid (fb_we),
        .byte_data  (fb_wdata)
    );

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Scoreboard bench for lcd_frame_capture: expected framebuffer writes are queued
// as pixels are driven and matched against the write port.
module tb_lcd_frame_capture;
    import dmg_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lcd_vsync = 1'b0;
    logic        lcd_hsync = 1'b0;
    logic        lcd_pixel = 1'b0;
    logic [1:0]  lcd_color = 2'd0;
    logic        err_clr = 1'b0;
    logic        fb_we;
    logic [13:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic        front_bank;
    logic        frame_done;
    logic [7:0]  frame_count;
    logic        err_long_line;
    logic        err_short_line;
    logic        err_short_frame;

    always #5 clk = ~clk;

    lcd_frame_capture dut (
        .clk             (clk),
        .rst             (rst),
        .lcd_vsync       (lcd_vsync),
        .lcd_hsync       (lcd_hsync),
        .lcd_pixel       (lcd_pixel),
        .lcd_color       (lcd_color),
        .err_clr         (err_clr),
        .fb_we           (fb_we),
        .fb_addr         (fb_addr),
        .fb_wdata        (fb_wdata),
        .front_bank      (front_bank),
        .frame_done      (frame_done),
        .frame_count     (frame_count),
        .err_long_line   (err_long_line),
        .err_short_line  (err_short_line),
        .err_short_frame (err_short_frame)
    );

    typedef struct packed {
        logic [13:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          nwrites = 0;
    int          ndone = 0;
    logic [13:0] last_addr = 14'd0;

    int exp_bank = 0;
    int exp_y = 0;
    int exp_front = 0;
    int exp_count = 0;
    int in_frame = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] addr_of(input int bank, input int y, input int g);
        return 14'(bank * 8192 + y * 40 + g);
    endfunction

    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst) begin
            if (frame_done) ndone++;
            if (fb_we) begin
                nwrites++;
                last_addr = fb_addr;
                if (sb_q.size() == 0) begin
                    chk("sb_nonempty_on_write", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("wr_addr", 32'(fb_addr), 32'(e.addr));
                    chk("wr_data", 32'(fb_wdata), 32'(e.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [13:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        sb_q.push_back(w);
    endtask

    task automatic start_frame();
        if (in_frame == 0) exp_bank = 1 - exp_front;
        exp_y = 0;
        in_frame = 1;
        lcd_vsync = 1'b1;
        repeat (3) tick();
        lcd_vsync = 1'b0;
        repeat (2) tick();
    endtask

    // mode: 0 random, 1 first four shades 3,0,2,1 with latency check, 2 all shade 3
    task automatic send_line(input int n, input int mode);
        logic [7:0] acc;
        int cnt;
        int c;
        int nacc;
        logic [7:0] pat;
        acc = 8'd0;
        cnt = 0;
        pat = 8'hC9;
        for (int i = 0; i < n; i++) begin
            if (mode == 2) c = 3;
            else if (mode == 1 && i < 4) c = int'(pat[7 - 2*i -: 2]);
            else c = int'($urandom_range(0, 3));
            lcd_pixel = 1'b1;
            lcd_color = 2'(c);
            if (i < LCD_W) begin
                acc = {acc[5:0], 2'(c)};
                cnt++;
                if (cnt == 4) begin
                    push_wr(addr_of(exp_bank, exp_y, i / 4), acc);
                    cnt = 0;
                end
            end
            tick();
            if (mode == 1 && i == 2) chk("we_before_4th", 32'(fb_we), 32'd0);
            if (mode == 1 && i == 3) begin
                chk("we_after_4th", 32'(fb_we), 32'd1);
                chk("c9_data", 32'(fb_wdata), 32'hC9);
                chk("c9_addr", 32'(fb_addr), 32'(addr_of(exp_bank, exp_y, 0)));
            end
        end
        lcd_pixel = 1'b0;
        nacc = (n < LCD_W) ? n : LCD_W;
        if (cnt != 0) push_wr(addr_of(exp_bank, exp_y, nacc / 4), acc << (2 * (4 - cnt)));
        lcd_hsync = 1'b1;
        repeat (3) tick();
        lcd_hsync = 1'b0;
        repeat (2) tick();
        exp_y++;
        if (exp_y == LCD_H) begin
            exp_front = exp_bank;
            exp_count = (exp_count + 1) % 256;
            in_frame = 0;
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_front"}, 32'(front_bank), 32'(exp_front));
        chk({tag, "_count"}, 32'(frame_count), 32'(exp_count));
        chk({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_errs(input string tag, input int l, input int s, input int f);
        chk({tag, "_err_long"}, 32'(err_long_line), 32'(l));
        chk({tag, "_err_short_line"}, 32'(err_short_line), 32'(s));
        chk({tag, "_err_short_frame"}, 32'(err_short_frame), 32'(f));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w0;
        int d0;

        repeat (3) tick();
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);
        chk("rst_fb_wdata", 32'(fb_wdata), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        check_status("rst");
        check_errs("rst", 0, 0, 0);
        rst = 1'b1;
        repeat (2) tick();

        // full frame into bank 1
        w0 = nwrites;
        d0 = ndone;
        start_frame();
        send_line(LCD_W, 1);
        for (int l = 1; l < LCD_H; l++) send_line(LCD_W, 0);
        repeat (3) tick();
        chk("fa_writes", 32'(nwrites - w0), 32'd5760);
        chk("fa_done", 32'(ndone - d0), 32'd1);
        chk("fa_last_addr", 32'(last_addr), 32'h367F);
        check_status("fa");
        check_errs("fa", 0, 0, 0);

        // short line, long line, then vsync mid-frame at y=100
        d0 = ndone;
        start_frame();
        send_line(6, 2);
        check_errs("short_line", 0, 1, 0);
        send_line(LCD_W + 2, 0);
        check_errs("long_line", 1, 1, 0);
        for (int l = 2; l < 100; l++) send_line(4, 0);
        start_frame();
        repeat (2) tick();
        check_errs("short_frame", 1, 1, 1);
        chk("sf_done", 32'(ndone - d0), 32'd0);
        check_status("sf");

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        check_errs("err_clr", 0, 0, 0);

        // the restarted frame completes into bank 0
        w0 = nwrites;
        d0 = ndone;
        for (int l = 0; l < LCD_H; l++) send_line(LCD_W, 0);
        repeat (3) tick();
        chk("fc_writes", 32'(nwrites - w0), 32'd5760);
        chk("fc_done", 32'(ndone - d0), 32'd1);
        chk("fc_last_addr", 32'(last_addr), 32'h167F);
        check_status("fc");
        check_errs("fc", 0, 0, 0);

        // async reset mid-line
        start_frame();
        begin : partial_line
            logic [7:0] acc;
            int c;
            acc = 8'd0;
            for (int i = 0; i < 50; i++) begin
                c = int'($urandom_range(0, 3));
                lcd_pixel = 1'b1;
                lcd_color = 2'(c);
                acc = {acc[5:0], 2'(c)};
                if (i % 4 == 3 && i < 48) push_wr(addr_of(exp_bank, exp_y, i / 4), acc);
                tick();
            end
            lcd_pixel = 1'b0;
        end
        repeat (2) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_fb_we", 32'(fb_we), 32'd0);
        chk("arst_front", 32'(front_bank), 32'd0);
        chk("arst_count", 32'(frame_count), 32'd0);
        chk("arst_sb_drained", 32'(sb_q.size()), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("arst_no_write", 32'(fb_we), 32'd0);
        end
        exp_front = 0;
        exp_count = 0;
        in_frame = 0;
        tick();
        rst = 1'b1;
        repeat (2) tick();

        w0 = nwrites;
        d0 = ndone;
        start_frame();
        for (int l = 0; l < LCD_H; l++) send_line(LCD_W, 0);
        repeat (3) tick();
        chk("fe_writes", 32'(nwrites - w0), 32'd5760);
        chk("fe_done", 32'(ndone - d0), 32'd1);
        check_status("fe");
        check_errs("fe", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
